// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, controller state encoding and default timeout for the HI/LO sequencer
package muldiv_pkg;
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MFHI = 3'd3;
  localparam logic [2:0] OP_MFLO = 3'd4;
  localparam logic [2:0] OP_MTHI = 3'd5;
  localparam logic [2:0] OP_MTLO = 3'd6;
  localparam int DEF_TIMEOUT = 64;
  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;
endpackage

// File: rtl/hilo_ctrl_if.sv
// hilo_ctrl_if: execute-stage op bus, mult/div unit bus and HI/LO status of the sequencer
interface hilo_ctrl_if #(parameter int W = 32);
  logic         op_valid;
  logic [2:0]   op_code;
  logic [W-1:0] op_a, op_b;
  logic         stall, rd_valid;
  logic [W-1:0] rd_data;
  logic         mult_start, div_start;
  logic [W-1:0] unit_a, unit_b;
  logic         mult_done, div_done;
  logic [W-1:0] mult_hi, mult_lo, div_hi, div_lo;
  logic [W-1:0] hi, lo;
  logic         busy, div_zero, err_timeout;
  modport master (
    output op_valid, op_code, op_a, op_b, mult_done, div_done, mult_hi, mult_lo, div_hi, div_lo,
    input  stall, rd_valid, rd_data, mult_start, div_start, unit_a, unit_b, hi, lo, busy, div_zero, err_timeout
  );
  modport slave (
    input  op_valid, op_code, op_a, op_b, mult_done, div_done, mult_hi, mult_lo, div_hi, div_lo,
    output stall, rd_valid, rd_data, mult_start, div_start, unit_a, unit_b, hi, lo, busy, div_zero, err_timeout
  );
endinterface

// File: rtl/hilo_timeout.sv
// hilo_timeout: run-length counter with clear/enable; tc flags the last permitted run cycle
module hilo_timeout #(parameter int TIMEOUT = 64) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : en ? cnt + CW'(1) : cnt;
  assign tc = en && cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: launches mult/div with one-cycle starts, captures results into HI/LO, stalls HI/LO ops while busy
module hilo_ctrl import muldiv_pkg::*; #(
  parameter int W       = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic       clk,
  input logic       rst,
  hilo_ctrl_if.slave bus
);
  state_t state, state_n;
  logic busy, stall, accept, idle_acc, launch_m, launch_d, dz, hit, tc, done_q;
  logic wr_hi, wr_lo, rd_hi, rd_lo;
  assign busy     = state != IDLE;
  assign stall    = bus.op_valid && busy && (bus.op_code inside {[OP_MULT:OP_MTLO]});
  assign accept   = bus.op_valid && !stall;
  assign idle_acc = accept && !busy;
  assign launch_m = idle_acc && bus.op_code == OP_MULT;
  assign launch_d = idle_acc && bus.op_code == OP_DIV && |bus.op_b;
  assign dz       = idle_acc && bus.op_code == OP_DIV && ~|bus.op_b;
  assign wr_hi    = idle_acc && bus.op_code == OP_MTHI;
  assign wr_lo    = idle_acc && bus.op_code == OP_MTLO;
  assign rd_hi    = accept && bus.op_code == OP_MFHI;
  assign rd_lo    = accept && bus.op_code == OP_MFLO;
  // Only a rising done edge of the running unit completes, so a level left high by the previous op is ignored
  assign hit = state == MUL_RUN ? bus.mult_done && !done_q :
               state == DIV_RUN ? bus.div_done && !done_q : 1'b0;
  hilo_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(launch_m || launch_d),
    .en (busy),
    .tc (tc)
  );
  always_comb begin
    state_n = state;
    if (launch_m) state_n = MUL_RUN;
    else if (launch_d) state_n = DIV_RUN;
    else if (hit || tc) state_n = IDLE;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // Track the done flag of the unit selected for the next cycle so the first run cycle already sees its old level
  always_ff @(posedge clk)
    done_q <= rst ? 1'b0 : (state_n == DIV_RUN ? bus.div_done : bus.mult_done);
  always_ff @(posedge clk)
    if (rst) begin
      bus.hi          <= '0;
      bus.lo          <= '0;
      bus.unit_a      <= '0;
      bus.unit_b      <= '0;
      bus.mult_start  <= 1'b0;
      bus.div_start   <= 1'b0;
      bus.div_zero    <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.mult_start <= launch_m;
      bus.div_start  <= launch_d;
      bus.div_zero   <= dz;
      if (launch_m || launch_d) begin
        bus.unit_a <= bus.op_a;
        bus.unit_b <= bus.op_b;
      end
      bus.hi <= hit ? (state == MUL_RUN ? bus.mult_hi : bus.div_hi) : wr_hi ? bus.op_a : bus.hi;
      bus.lo <= hit ? (state == MUL_RUN ? bus.mult_lo : bus.div_lo) : wr_lo ? bus.op_a : bus.lo;
      if (tc && !hit) bus.err_timeout <= 1'b1;
    end
  assign bus.busy     = busy;
  assign bus.stall    = stall;
  assign bus.rd_valid = rd_hi || rd_lo;
  assign bus.rd_data  = rd_hi ? bus.hi : rd_lo ? bus.lo : '0;
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: table-driven IDLE op vectors plus directed mult/div/stale-done/timeout/reset sequences
module tb_hilo_ctrl;
  import muldiv_pkg::*;
  localparam int W  = 32;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  hilo_ctrl_if #(.W(W)) bus();
  hilo_ctrl #(.W(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic s_stall, s_rdv;
  logic [31:0] s_rd;

  int mult_lat = 33;
  int stale_hold = 0;
  bit mult_hang = 0;
  int m_cnt = 0, m_hold = 0, d_cnt = 0;
  logic m_done = 1'b0, d_done = 1'b0;
  logic [63:0] m_res = '0;
  logic [31:0] d_q = '0, d_r = '0;
  assign bus.mult_done = m_done;
  assign bus.mult_hi   = m_res[63:32];
  assign bus.mult_lo   = m_res[31:0];
  assign bus.div_done  = d_done;
  assign bus.div_hi    = d_r;
  assign bus.div_lo    = d_q;

  // Unit models run on negedge; mult can hold a stale done for stale_hold cycles or hang forever
  always @(negedge clk) begin
    if (bus.mult_start) begin
      m_cnt  <= mult_lat;
      m_hold <= stale_hold;
      m_res  <= 64'(longint'($signed(bus.unit_a)) * longint'($signed(bus.unit_b)));
      if (stale_hold == 0) m_done <= 1'b0;
    end else if (m_hold != 0) begin
      m_hold <= m_hold - 1;
      if (m_hold == 1) m_done <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !mult_hang) m_done <= 1'b1;
    end
  end
  always @(negedge clk) begin
    if (bus.div_start) begin
      d_cnt  <= 4;
      d_done <= 1'b0;
      d_q    <= $signed(bus.unit_a) / $signed(bus.unit_b);
      d_r    <= $signed(bus.unit_a) % $signed(bus.unit_b);
    end else if (d_cnt != 0) begin
      d_cnt <= d_cnt - 1;
      if (d_cnt == 1) d_done <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.op_valid = v;
    bus.op_code  = c;
    bus.op_a     = a;
    bus.op_b     = b;
    #2;
    s_stall = bus.stall;
    s_rdv   = bus.rd_valid;
    s_rd    = bus.rd_data;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic v; logic [2:0] c; logic [31:0] a, b;
    logic rdv; logic [31:0] rd, hi, lo; logic dz;
  } vec_t;
  vec_t vt[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vt[0] = '{1'b1, OP_MTHI, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0,        32'hDEADBEEF, 32'h0,        1'b0};
    vt[1] = '{1'b1, OP_MFHI, 32'h0,        32'h0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        1'b0};
    vt[2] = '{1'b1, OP_MTLO, 32'h12345678, 32'h0, 1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678, 1'b0};
    vt[3] = '{1'b1, OP_MFLO, 32'h0,        32'h0, 1'b1, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 1'b0};
    vt[4] = '{1'b1, OP_NOP,  32'hFFFF,     32'h1, 1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678, 1'b0};
    vt[5] = '{1'b1, 3'd7,    32'hFFFF,     32'h1, 1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678, 1'b0};
    vt[6] = '{1'b1, OP_DIV,  32'd9,        32'h0, 1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678, 1'b1};
    vt[7] = '{1'b0, OP_MFHI, 32'h0,        32'h0, 1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678, 1'b0};
    vt[8] = '{1'b0, OP_MTHI, 32'h1111,     32'h0, 1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678, 1'b0};
    vt[9] = '{1'b1, OP_MTHI, 32'hCAFE0001, 32'h0, 1'b0, 32'h0,        32'hCAFE0001, 32'h12345678, 1'b0};
    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op_code = OP_NOP; bus.op_a = '0; bus.op_b = '0;
    step(0, OP_NOP, 0, 0);
    step(0, OP_NOP, 0, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mult_start", bus.mult_start, 0);
    chk("rst_div_start", bus.div_start, 0);
    chk("rst_err", bus.err_timeout, 0);
    chk("rst_div_zero", bus.div_zero, 0);
    chk("rst_unit_a", bus.unit_a, 0);
    rst = 1'b0;

    foreach (vt[i]) begin
      step(vt[i].v, vt[i].c, vt[i].a, vt[i].b);
      chk($sformatf("v%0d_stall", i), s_stall, 0);
      chk($sformatf("v%0d_rd_valid", i), s_rdv, vt[i].rdv);
      chk($sformatf("v%0d_rd_data", i), s_rd, vt[i].rd);
      chk($sformatf("v%0d_hi", i), bus.hi, vt[i].hi);
      chk($sformatf("v%0d_lo", i), bus.lo, vt[i].lo);
      chk($sformatf("v%0d_div_zero", i), bus.div_zero, vt[i].dz);
      chk($sformatf("v%0d_busy", i), bus.busy, 0);
    end

    step(1, OP_MULT, 32'hFFFFFFFD, 32'd7);
    chk("mul_start_hi", bus.mult_start, 1);
    chk("mul_no_div_start", bus.div_start, 0);
    chk("mul_busy", bus.busy, 1);
    chk("mul_unit_a", bus.unit_a, 32'hFFFFFFFD);
    chk("mul_unit_b", bus.unit_b, 32'd7);
    step(1, OP_NOP, 0, 0);
    chk("mul_nop_stall", s_stall, 0);
    chk("mul_start_lo", bus.mult_start, 0);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      step(1, OP_MFHI, 0, 0);
      if (!s_stall) break;
      n++;
    end
    chk("mfhi_stall_cycles", n, 33);
    chk("mfhi_rd_valid", s_rdv, 1);
    chk("mfhi_rd_data", s_rd, 32'hFFFFFFFF);
    step(1, OP_MFLO, 0, 0);
    chk("mflo_rd_valid", s_rdv, 1);
    chk("mflo_rd_data", s_rd, 32'hFFFFFFEB);
    chk("mul_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);
    chk("mul_unit_a_stable", bus.unit_a, 32'hFFFFFFFD);

    step(1, OP_DIV, 32'd17, 32'd5);
    chk("div_start_hi", bus.div_start, 1);
    chk("div_no_mult_start", bus.mult_start, 0);
    chk("div_busy", bus.busy, 1);
    step(1, OP_NOP, 0, 0);
    chk("div_start_lo", bus.div_start, 0);
    for (int k = 0; k < 50 && bus.busy; k++) step(1, OP_NOP, 0, 0);
    chk("div_busy_end", bus.busy, 0);
    chk("div_hi_rem", bus.hi, 2);
    chk("div_lo_quot", bus.lo, 3);

    stale_hold = 3;
    step(1, OP_MULT, 32'd5, 32'd6);
    repeat (5) step(1, OP_NOP, 0, 0);
    chk("stale_busy", bus.busy, 1);
    chk("stale_hi_kept", bus.hi, 2);
    chk("stale_lo_kept", bus.lo, 3);
    for (int k = 0; k < 60 && bus.busy; k++) step(1, OP_NOP, 0, 0);
    chk("stale_hi", bus.hi, 0);
    chk("stale_lo", bus.lo, 30);
    stale_hold = 0;

    mult_hang = 1;
    step(1, OP_MULT, 32'd1, 32'd1);
    n = 1;
    for (int k = 0; k < 200; k++) begin
      step(1, OP_NOP, 0, 0);
      if (!bus.busy) break;
      n++;
    end
    chk("to_busy_cycles", n, TO);
    chk("to_err", bus.err_timeout, 1);
    chk("to_hi", bus.hi, 0);
    chk("to_lo", bus.lo, 30);
    step(1, OP_MTHI, 32'h55, 0);
    chk("to_err_sticky", bus.err_timeout, 1);
    chk("to_mthi_after", bus.hi, 32'h55);

    mult_hang = 0;
    step(1, OP_MULT, 32'd2, 32'd3);
    repeat (5) step(1, OP_NOP, 0, 0);
    chk("rr_busy_before", bus.busy, 1);
    rst = 1'b1;
    step(1, OP_NOP, 0, 0);
    chk("rr_busy", bus.busy, 0);
    chk("rr_hi", bus.hi, 0);
    chk("rr_lo", bus.lo, 0);
    chk("rr_unit_a", bus.unit_a, 0);
    chk("rr_unit_b", bus.unit_b, 0);
    chk("rr_mult_start", bus.mult_start, 0);
    chk("rr_err", bus.err_timeout, 0);
    rst = 1'b0;
    repeat (45) step(1, OP_NOP, 0, 0);
    chk("rr_late_hi", bus.hi, 0);
    chk("rr_late_lo", bus.lo, 0);
    chk("rr_late_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
